// File: rtl/ball_motion.sv
// ball_motion
// -----------------------------------------------------------------------------
// Fixed-point ball position/velocity engine for the breakout playfield.
// Collision and paddle events seen while a frame is being drawn are latched,
// and the ball makes one motion step per frame. That step applies reflection,
// paddle speed-up and loss detection. A small IDLE/MOVING/LOST state machine
// handles serving and losing the ball.
//
// Ports
//   clk              : single clock, rising edge
//   nRst             : synchronous active-low reset
//   frame_pulse      : one-cycle end-of-frame strobe
//   do_move          : motion enable, sampled together with frame_pulse
//   serve            : launch request (honoured in IDLE and LOST)
//   collision        : qualifier for the four side flags
//   ball_*_col       : which side(s) of the ball touched something
//   paddle_hit       : ball/paddle contact on this pixel
//   x, y             : integer ball position
//   vel_x, vel_y     : signed velocity in 2^-FRAC px/frame
//   state            : 00 IDLE, 01 MOVING, 10 LOST
//   ball_lost        : one-cycle pulse on entering LOST
// -----------------------------------------------------------------------------
module ball_motion #(
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int FRAC          = 1,
    parameter int VEL_W         = 4,
    parameter int INITIAL_X     = 320,
    parameter int INITIAL_Y     = 452,
    parameter int INITIAL_VEL_X = 2,
    parameter int INITIAL_VEL_Y = -2,
    parameter int MAX_SPEED     = 6,
    parameter int SPEEDUP_HITS  = 4,
    parameter int BOTTOM_Y      = 470
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             frame_pulse,
    input  logic             do_move,
    input  logic             serve,
    input  logic             collision,
    input  logic             ball_top_col,
    input  logic             ball_bottom_col,
    input  logic             ball_left_col,
    input  logic             ball_right_col,
    input  logic             paddle_hit,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [VEL_W-1:0] vel_x,
    output logic [VEL_W-1:0] vel_y,
    output logic [1:0]       state,
    output logic             ball_lost
);

    localparam int XP   = X_W + FRAC;
    localparam int YP   = Y_W + FRAC;
    localparam int HC_W = $clog2(SPEEDUP_HITS + 1);

    localparam logic [XP-1:0]           INIT_XPOS = XP'(INITIAL_X * (2 ** FRAC));
    localparam logic [YP-1:0]           INIT_YPOS = YP'(INITIAL_Y * (2 ** FRAC));
    localparam logic signed [VEL_W-1:0] INIT_VX   = VEL_W'(INITIAL_VEL_X);
    localparam logic signed [VEL_W-1:0] INIT_VY   = VEL_W'(INITIAL_VEL_Y);
    localparam logic signed [VEL_W-1:0] VMAX      = VEL_W'(MAX_SPEED);
    localparam logic signed [VEL_W-1:0] VONE      = VEL_W'(1);
    localparam logic signed [VEL_W-1:0] VZERO     = '0;
    localparam logic [Y_W-1:0]          BOTTOM    = Y_W'(BOTTOM_Y);
    localparam logic [HC_W-1:0]         HITS_WRAP = HC_W'(SPEEDUP_HITS);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVING = 2'b01,
        LOST   = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [XP-1:0]           xPos_q, xPos_d;
    logic [YP-1:0]           yPos_q, yPos_d;
    logic signed [VEL_W-1:0] velX_q, velX_d;
    logic signed [VEL_W-1:0] velY_q, velY_d;
    logic                    vflag_q, vflag_d;
    logic                    hflag_q, hflag_d;
    logic                    pflag_q, pflag_d;
    logic [HC_W-1:0]         hitCnt_q, hitCnt_d;
    logic                    ballLost_q, ballLost_d;

    logic signed [VEL_W-1:0] reflX, reflY;
    logic [XP-1:0]           movedX;
    logic [YP-1:0]           movedY;
    logic [HC_W-1:0]         hitInc;

    // One speed step: grow the magnitude by one, keep the sign, never exceed
    // MAX_SPEED, and leave a stationary axis stationary.
    function automatic logic signed [VEL_W-1:0] speedStep(input logic signed [VEL_W-1:0] v);
        if (v > VZERO)
            return (v < VMAX) ? v + VONE : v;
        else if (v < VZERO)
            return (v > -VMAX) ? v - VONE : v;
        else
            return VZERO;
    endfunction

    // Reflection flips the velocity first; the position then moves by the
    // flipped velocity, which is the same as subtracting the old one.
    assign reflX  = hflag_q ? -velX_q : velX_q;
    assign reflY  = vflag_q ? -velY_q : velY_q;
    assign movedX = xPos_q + {{(XP - VEL_W){reflX[VEL_W-1]}}, reflX};
    assign movedY = yPos_q + {{(YP - VEL_W){reflY[VEL_W-1]}}, reflY};
    assign hitInc = hitCnt_q + HC_W'(1);

    // Next-state logic. Event latches are updated every cycle. Serve overrides
    // everything outside MOVING. Motion happens once per frame while MOVING.
    always_comb begin
        state_d    = state_q;
        xPos_d     = xPos_q;
        yPos_d     = yPos_q;
        velX_d     = velX_q;
        velY_d     = velY_q;
        vflag_d    = vflag_q;
        hflag_d    = hflag_q;
        pflag_d    = pflag_q;
        hitCnt_d   = hitCnt_q;

        if (frame_pulse) begin
            vflag_d = 1'b0;
            hflag_d = 1'b0;
            pflag_d = 1'b0;
        end else begin
            if (collision) begin
                vflag_d = vflag_q | ball_top_col | ball_bottom_col;
                hflag_d = hflag_q | ball_left_col | ball_right_col;
            end
            if (paddle_hit)
                pflag_d = 1'b1;
        end

        case (state_q)
            IDLE, LOST: begin
                if (serve) begin
                    xPos_d   = INIT_XPOS;
                    yPos_d   = INIT_YPOS;
                    velX_d   = INIT_VX;
                    velY_d   = INIT_VY;
                    hitCnt_d = '0;
                    vflag_d  = 1'b0;
                    hflag_d  = 1'b0;
                    pflag_d  = 1'b0;
                    state_d  = MOVING;
                end
            end
            MOVING: begin
                if (frame_pulse && do_move) begin
                    xPos_d = movedX;
                    yPos_d = movedY;
                    velX_d = reflX;
                    velY_d = reflY;
                    // The speed step acts on the reflected velocity, but the
                    // position above has already used the pre-step value.
                    if (pflag_q) begin
                        if (hitInc == HITS_WRAP) begin
                            hitCnt_d = '0;
                            velX_d   = speedStep(reflX);
                            velY_d   = speedStep(reflY);
                        end else begin
                            hitCnt_d = hitInc;
                        end
                    end
                    if (movedY[YP-1:FRAC] >= BOTTOM)
                        state_d = LOST;
                end
            end
            default: state_d = IDLE;
        endcase

        ballLost_d = (state_d == LOST) && (state_q != LOST);
    end

    // State register with synchronous reset back to the serve position.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q    <= IDLE;
            xPos_q     <= INIT_XPOS;
            yPos_q     <= INIT_YPOS;
            velX_q     <= INIT_VX;
            velY_q     <= INIT_VY;
            vflag_q    <= 1'b0;
            hflag_q    <= 1'b0;
            pflag_q    <= 1'b0;
            hitCnt_q   <= '0;
            ballLost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            xPos_q     <= xPos_d;
            yPos_q     <= yPos_d;
            velX_q     <= velX_d;
            velY_q     <= velY_d;
            vflag_q    <= vflag_d;
            hflag_q    <= hflag_d;
            pflag_q    <= pflag_d;
            hitCnt_q   <= hitCnt_d;
            ballLost_q <= ballLost_d;
        end
    end

    assign x         = xPos_q[XP-1:FRAC];
    assign y         = yPos_q[YP-1:FRAC];
    assign vel_x     = velX_q;
    assign vel_y     = velY_q;
    assign state     = state_q;
    assign ball_lost = ballLost_q;

endmodule

// File: doc/ball_motion.md
# ball_motion

Parametrised ball position/velocity engine for the breakout playfield, succeeding the fixed-format ball logic. Holds a fixed-point ball position and signed velocity, accumulates collision and paddle-hit events during the drawn frame, and applies one motion update per frame. Adds corner reflection, paddle-driven speed-up, a serve/lost state machine and a configurable bottom loss line. It feeds `x`/`y` to the sprite renderer and `ball_lost` to game control.

## Interface
- `X_W`, 10: integer pixel width of x.
- `Y_W`, 9: integer pixel width of y.
- `FRAC`, 1: fractional position bits, shared by x and y.
- `VEL_W`, 4: signed velocity width, in units of 2^-FRAC px/frame.
- `INITIAL_X`, 320: serve/reset x in pixels.
- `INITIAL_Y`, 452: serve/reset y in pixels.
- `INITIAL_VEL_X`, 2: serve/reset x velocity (signed).
- `INITIAL_VEL_Y`, -2: serve/reset y velocity (signed).
- `MAX_SPEED`, 6: speed-up magnitude ceiling. Must be ≤ 2^(VEL_W-1)-1.
- `SPEEDUP_HITS`, 4: paddle hits per speed step, ≥1.
- `BOTTOM_Y`, 470: loss line in pixels.

Ports:
- `clk` in 1: single clock, rising edge.
- `nRst` in 1: reset is synchronous and active-low.
- `frame_pulse` in 1: one-cycle end-of-frame strobe.
- `do_move` in 1: motion enable, sampled with `frame_pulse`.
- `serve` in 1: launch request.
- `collision` in 1: qualifier for the side flags.
- `ball_top_col`, `ball_bottom_col`, `ball_left_col`, `ball_right_col` in 1 each: side flags.
- `paddle_hit` in 1: ball/paddle contact this pixel.
- `x` out X_W: integer x.
- `y` out Y_W: integer y.
- `vel_x`, `vel_y` out VEL_W: current signed velocities.
- `state` out 2: 00 IDLE, 01 MOVING, 10 LOST.
- `ball_lost` out 1: one-cycle loss pulse.

## Operation
- Position registers are unsigned, X_W+FRAC and Y_W+FRAC bits wide.
  - `x`/`y` are the integer (upper) bits.
  - Add/subtract wraps modulo 2^width. There is no clamping; walls come from the collision inputs.
- Latches (`vflag` = top|bottom, `hflag` = left|right, `pflag` = paddle):
  - `frame_pulse` clears all latches.
  - Otherwise, `collision` ORs in the side flags.
  - `paddle_hit` sets `pflag` regardless of `collision`.
  - An event in the same cycle as `frame_pulse` is dropped.
- Update condition: `frame_pulse & do_move & state==MOVING`. Cases use latched values:
  - neither flag: `pos += vel` on both axes.
  - `vflag` only: `vel_y <= -vel_y`, `y_pos -= vel_y`, `x_pos += vel_x`.
  - `hflag` only: `vel_x <= -vel_x`, `x_pos -= vel_x`, `y_pos += vel_y`.
  - both: negate both velocities, subtract both.
- Speed-up:
  - On an update with `pflag`, `hit_cnt` increments. Reaching SPEEDUP_HITS, it wraps to 0 and a speed step occurs.
  - Speed step: each velocity magnitude +1, sign kept, saturating at MAX_SPEED. A zero velocity stays 0.
  - The step applies to the post-reflection velocity. Position in that update uses the pre-step velocity.
- Loss: after an update, if the new integer y ≥ BOTTOM_Y, go to LOST. Position and velocity freeze.
- FSM:
  - IDLE: holds the reset/serve values.
  - IDLE/LOST + `serve`: reload initial position and velocity, clear `hit_cnt` and latches, go to MOVING.
  - `serve` in MOVING is ignored.
  - Exit from MOVING is only via loss or reset.

## Timing
- All outputs are registered. `x`, `y`, `vel_*` and `state` change on the edge after the qualifying cycle (latency 1).
- `ball_lost` is high for exactly the first cycle in which `state`==LOST.
- `serve` together with `frame_pulse` in IDLE/LOST: the serve wins and no motion occurs that frame.
- Reset has priority over everything, including mid-frame. Reset values:
  - `x`=INITIAL_X, `y`=INITIAL_Y.
  - `vel_x`=INITIAL_VEL_X, `vel_y`=INITIAL_VEL_Y.
  - `state`=IDLE, `ball_lost`=0.
  - latches and `hit_cnt` cleared.
- `frame_pulse` with `do_move`=0 still clears the latches, with no motion.

## Test plan
- Defaults. Reset, pulse `serve`, then `frame_pulse`+`do_move` → x=321, y=451, state=01.
- Top collision mid-frame from (321,451) vel(2,-2), then frame → vel_y=+2, y=452, x=322.
- Top+left collision in one frame → vel(-2,+2), both axes step back one pixel. Same-cycle `collision`+`frame_pulse` → ignored.
- SPEEDUP_HITS=2:
  - two frames each with `paddle_hit` → after the second, `vel_*` magnitude 3 with signs kept, position moved using magnitude 2.
  - further steps saturate at MAX_SPEED.
- BOTTOM_Y=453, vel_y=+2, y=452 → after the update y=453, state=10, `ball_lost` high for one cycle. Later frames do not move the ball. `serve` restores (320,452), IDLE skipped.
- Assert `nRst`=0 for one cycle in MOVING mid-frame → all reset values on the next edge. A `frame_pulse` in the reset cycle causes no update.
